// File: rtl/tlc_pkg.sv
// Shared lamp codes, controller state encoding and default phase timings
// for the multi-approach traffic light controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'b00,
        LAMP_YELLOW = 2'b01,
        LAMP_GREEN  = 2'b10
    } lamp_e;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALLRED_A    = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4,
        ST_ALLRED_B    = 3'd5,
        ST_FLASH       = 3'd6
    } state_e;

    localparam int DEF_N_SIDE     = 2;
    localparam int DEF_CNT_W      = 6;
    localparam int DEF_T_MAIN_MIN = 20;
    localparam int DEF_T_SIDE     = 10;
    localparam int DEF_T_YELLOW   = 4;
    localparam int DEF_T_ALLRED   = 2;
    localparam int DEF_T_FLASH    = 2;

    // Width of a side index; a single side still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlc_rr_arb.sv
// Round-robin pick among pending side requests, starting just after the
// side served last and wrapping around.
module tlc_rr_arb
    import tlc_pkg::*;
#(
    parameter  int N  = 2,
    localparam int GW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] win,
    output logic          any
);

    logic [N-1:0] rot;

    always_comb begin
        win = last;
        any = |req;
        rot = '0;
        // Walk from the farthest candidate to the nearest so the nearest hit sticks.
        for (int k = N; k >= 1; k--) begin
            rot = req >> ((int'(last) + k) % N);
            if (rot[0]) win = GW'((int'(last) + k) % N);
        end
    end

endmodule

// File: rtl/tlc_multi_fsm.sv
// Main road / N side road traffic light controller with request latching,
// round-robin side service and a night flashing mode. All outputs registered.
module tlc_multi_fsm
    import tlc_pkg::*;
#(
    parameter  int N_SIDE     = DEF_N_SIDE,
    parameter  int CNT_W      = DEF_CNT_W,
    parameter  int T_MAIN_MIN = DEF_T_MAIN_MIN,
    parameter  int T_SIDE     = DEF_T_SIDE,
    parameter  int T_YELLOW   = DEF_T_YELLOW,
    parameter  int T_ALLRED   = DEF_T_ALLRED,
    parameter  int T_FLASH    = DEF_T_FLASH,
    localparam int GW         = idx_w(N_SIDE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SIDE-1:0]   side_sensor,
    input  logic                night,
    output logic [1:0]          main_s,
    output logic [2*N_SIDE-1:0] side_s,
    output logic [2:0]          state,
    output logic [GW-1:0]       grant_id,
    output logic [N_SIDE-1:0]   req_pending
);

    if (N_SIDE < 1 || N_SIDE > 8) begin : g_bad_n_side
        $error("tlc_multi_fsm: N_SIDE must be within 1..8");
    end
    if (T_MAIN_MIN > 2**CNT_W || T_SIDE > 2**CNT_W || T_YELLOW > 2**CNT_W ||
        T_ALLRED > 2**CNT_W || T_FLASH > 2**CNT_W) begin : g_bad_cnt_w
        $error("tlc_multi_fsm: a phase duration does not fit the phase counter");
    end
    if (T_MAIN_MIN < 1 || T_SIDE < 1 || T_YELLOW < 1 || T_ALLRED < 1 ||
        T_FLASH < 1) begin : g_bad_timing
        $error("tlc_multi_fsm: phase durations must be at least one cycle");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] MG_END   = CNT_W'(T_MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SG_END   = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] Y_END    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_END   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] FL_END   = CNT_W'(T_FLASH - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic                flash_q, flash_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [N_SIDE-1:0]   req_q, req_d;
    logic [N_SIDE-1:0]   serve_mask;
    logic [1:0]          main_q, main_d;
    logic [2*N_SIDE-1:0] side_q, side_d;
    logic [GW-1:0]       arb_win;
    logic                arb_any;

    tlc_rr_arb #(.N(N_SIDE)) u_arb (
        .req  (req_q),
        .last (grant_q),
        .win  (arb_win),
        .any  (arb_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        flash_d = flash_q;
        fcnt_d  = fcnt_q;
        // The side being served cannot re-request itself until its green/yellow ends.
        serve_mask = (state_q == ST_SIDE_GREEN || state_q == ST_SIDE_YELLOW)
                     ? (N_SIDE'(1) << grant_q) : '0;
        req_d = req_q | (side_sensor & ~serve_mask);

        unique case (state_q)
            ST_MAIN_GREEN: begin
                if (count_q >= MG_END && (arb_any || night)) state_d = ST_MAIN_YELLOW;
            end
            ST_MAIN_YELLOW: begin
                if (count_q == Y_END) state_d = ST_ALLRED_A;
            end
            ST_ALLRED_A: begin
                if (count_q == AR_END) begin
                    if (night) begin
                        state_d = ST_FLASH;
                        fcnt_d  = '0;
                        flash_d = 1'b0;
                    end else if (arb_any) begin
                        state_d = ST_SIDE_GREEN;
                        grant_d = arb_win;
                        req_d   = req_d & ~(N_SIDE'(1) << arb_win);
                    end else begin
                        state_d = ST_MAIN_GREEN;
                    end
                end
            end
            ST_SIDE_GREEN: begin
                if (count_q == SG_END) state_d = ST_SIDE_YELLOW;
            end
            ST_SIDE_YELLOW: begin
                if (count_q == Y_END) state_d = ST_ALLRED_B;
            end
            ST_ALLRED_B: begin
                if (count_q == AR_END) state_d = ST_MAIN_GREEN;
            end
            ST_FLASH: begin
                // Night release is only honoured at the end of a flash interval.
                if (fcnt_q == FL_END) begin
                    if (!night) begin
                        state_d = ST_MAIN_GREEN;
                    end else begin
                        flash_d = ~flash_q;
                        fcnt_d  = '0;
                    end
                end else begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_MAIN_GREEN;
        endcase

        if (state_d != state_q)    count_d = '0;
        else if (count_q == CNT_MAX) count_d = count_q;
        else                       count_d = count_q + CNT_W'(1);

        main_d = LAMP_RED;
        side_d = '0;
        case (state_d)
            ST_MAIN_GREEN:  main_d = LAMP_GREEN;
            ST_MAIN_YELLOW: main_d = LAMP_YELLOW;
            ST_SIDE_GREEN:  side_d = (2*N_SIDE)'(LAMP_GREEN) << {grant_d, 1'b0};
            ST_SIDE_YELLOW: side_d = (2*N_SIDE)'(LAMP_YELLOW) << {grant_d, 1'b0};
            ST_FLASH:       main_d = flash_d ? LAMP_RED : LAMP_YELLOW;
            default:        main_d = LAMP_RED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_MAIN_GREEN;
            count_q <= '0;
            fcnt_q  <= '0;
            flash_q <= 1'b0;
            grant_q <= GW'(N_SIDE - 1);
            req_q   <= '0;
            main_q  <= LAMP_GREEN;
            side_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            fcnt_q  <= fcnt_d;
            flash_q <= flash_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            main_q  <= main_d;
            side_q  <= side_d;
        end
    end

    assign main_s      = main_q;
    assign side_s      = side_q;
    assign state       = state_q;
    assign grant_id    = grant_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_tlc_multi_fsm.sv
// Self-checking bench for tlc_multi_fsm: phase-timeline reference model,
// directed timeline checks and randomized sensor/night/reset stimulus.
module tb_tlc_multi_fsm;

    localparam int N_SIDE     = 2;
    localparam int T_MAIN_MIN = 20;
    localparam int T_SIDE     = 10;
    localparam int T_YELLOW   = 4;
    localparam int T_ALLRED   = 2;
    localparam int T_FLASH    = 2;
    localparam int GW         = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;

    localparam int P_MG = 0, P_MY = 1, P_AA = 2, P_SG = 3, P_SY = 4, P_AB = 5, P_FL = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_SIDE-1:0]   side_sensor = '0;
    logic                night = 1'b0;
    logic [1:0]          main_s;
    logic [2*N_SIDE-1:0] side_s;
    logic [2:0]          state;
    logic [GW-1:0]       grant_id;
    logic [N_SIDE-1:0]   req_pending;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    // Reference model: which phase we are in and how long we have been in it.
    int              m_phase   = P_MG;
    int              m_elapsed = 0;
    int              m_grant   = N_SIDE - 1;
    bit [N_SIDE-1:0] m_req     = '0;

    tlc_multi_fsm #(
        .N_SIDE(N_SIDE), .CNT_W(6), .T_MAIN_MIN(T_MAIN_MIN), .T_SIDE(T_SIDE),
        .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .T_FLASH(T_FLASH)
    ) dut (
        .clk(clk), .rst(rst), .side_sensor(side_sensor), .night(night),
        .main_s(main_s), .side_s(side_s), .state(state),
        .grant_id(grant_id), .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, want);
        end
    endtask

    function automatic int rr_pick(input bit [N_SIDE-1:0] r, input int last);
        bit [N_SIDE-1:0] t;
        for (int k = 1; k <= N_SIDE; k++) begin
            t = r >> ((last + k) % N_SIDE);
            if (t[0]) return (last + k) % N_SIDE;
        end
        return last;
    endfunction

    task automatic model_step();
        bit [N_SIDE-1:0] busy;
        bit [N_SIDE-1:0] nreq;
        int lasted;
        int nxt;
        busy   = (m_phase == P_SG || m_phase == P_SY) ? (N_SIDE'(1) << m_grant) : '0;
        nreq   = m_req | (side_sensor & ~busy);
        lasted = m_elapsed + 1;
        nxt    = m_phase;
        case (m_phase)
            P_MG: if (lasted >= T_MAIN_MIN && (m_req != 0 || night)) nxt = P_MY;
            P_MY: if (lasted == T_YELLOW) nxt = P_AA;
            P_AA: if (lasted == T_ALLRED) begin
                if (night) nxt = P_FL;
                else if (m_req != 0) begin
                    m_grant = rr_pick(m_req, m_grant);
                    nreq    = nreq & ~(N_SIDE'(1) << m_grant);
                    nxt     = P_SG;
                end else nxt = P_MG;
            end
            P_SG: if (lasted == T_SIDE) nxt = P_SY;
            P_SY: if (lasted == T_YELLOW) nxt = P_AB;
            P_AB: if (lasted == T_ALLRED) nxt = P_MG;
            P_FL: if (lasted % T_FLASH == 0 && !night) nxt = P_MG;
            default: nxt = P_MG;
        endcase
        m_req     = nreq;
        m_elapsed = (nxt == m_phase) ? lasted : 0;
        m_phase   = nxt;
    endtask

    function automatic int exp_main();
        case (m_phase)
            P_MG:    return 2;
            P_MY:    return 1;
            P_FL:    return ((m_elapsed / T_FLASH) % 2 == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_side();
        if (m_phase == P_SG) return 2 << (2 * m_grant);
        if (m_phase == P_SY) return 1 << (2 * m_grant);
        return 0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_phase = P_MG; m_elapsed = 0; m_grant = N_SIDE - 1; m_req = '0; cyc = 0;
        end else begin
            model_step();
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("state", int'(state), m_phase);
            check("main_s", int'(main_s), exp_main());
            check("side_s", int'(side_s), exp_side());
            check("grant_id", int'(grant_id), m_grant);
            check("req_pending", int'(req_pending), int'(m_req));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        side_sensor = '0;
        night = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int              srv[4];
    int              n_srv;
    int              mg_run;
    logic [2:0]      prev_state;
    logic [N_SIDE-1:0] sel;
    logic [N_SIDE-1:0] rnd;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_main", int'(main_s), 2);
        check("rst_side", int'(side_s), 0);
        check("rst_req", int'(req_pending), 0);
        check("rst_grant", int'(grant_id), N_SIDE - 1);
        cmp_en = 1'b1;
        rst = 1'b1;

        // Idle: main green holds forever without requests.
        wait_cyc(199);
        check("idle_state", int'(state), 0);
        check("idle_main", int'(main_s), 2);
        check("idle_side", int'(side_s), 0);

        // Single side-1 request pulse.
        do_reset();
        wait_cyc(5);
        side_sensor = 2'b10;
        @(negedge clk);
        side_sensor = '0;
        check("pulse_latched", int'(req_pending), 2);
        wait_cyc(19); check("t19_state", int'(state), 0);
        wait_cyc(20); check("t20_state", int'(state), 1);
        wait_cyc(24); check("t24_state", int'(state), 2);
        wait_cyc(26); check("t26_state", int'(state), 3);
        check("t26_grant", int'(grant_id), 1);
        check("t26_req", int'(req_pending), 0);
        check("t26_side", int'(side_s), 8);
        wait_cyc(35); check("t35_state", int'(state), 3);
        wait_cyc(36); check("t36_state", int'(state), 4);
        wait_cyc(40); check("t40_state", int'(state), 5);
        wait_cyc(42); check("t42_state", int'(state), 0);

        // Asynchronous reset in the middle of a side green.
        do_reset();
        wait_cyc(3);
        side_sensor = 2'b01;
        @(negedge clk);
        side_sensor = '0;
        wait_cyc(28);
        side_sensor = 2'b10;
        wait_cyc(30);
        check("pre_rst_state", int'(state), 3);
        check("pre_rst_req", int'(req_pending), 2);
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_main", int'(main_s), 2);
        check("async_rst_side", int'(side_s), 0);
        check("async_rst_req", int'(req_pending), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(19); check("post_rst_t19", int'(state), 0);
        wait_cyc(20); check("post_rst_t20", int'(state), 1);
        side_sensor = '0;

        // Night mode entry, flashing and release at an interval boundary.
        do_reset();
        wait_cyc(30);
        night = 1'b1;
        wait_cyc(31); check("n31_state", int'(state), 1);
        wait_cyc(35); check("n35_state", int'(state), 2);
        wait_cyc(37); check("n37_state", int'(state), 6); check("n37_main", int'(main_s), 1);
        wait_cyc(38); check("n38_main", int'(main_s), 1);
        wait_cyc(39); check("n39_main", int'(main_s), 0);
        wait_cyc(40); check("n40_main", int'(main_s), 0);
        wait_cyc(41); check("n41_main", int'(main_s), 1);
        wait_cyc(42); check("n42_state", int'(state), 6);
        night = 1'b0;
        wait_cyc(43); check("n43_state", int'(state), 0); check("n43_main", int'(main_s), 2);

        // Both sensors held: alternate service with full main green in between.
        do_reset();
        side_sensor = '1;
        n_srv = 0; mg_run = 0; prev_state = 3'd0;
        for (int i = 0; i < 4; i++) srv[i] = -1;
        for (int c = 0; c < 200; c++) begin
            if (state == 3'd0) mg_run++;
            if (state == 3'd3 && prev_state != 3'd3) begin
                check("alt_main_green_len", (mg_run >= T_MAIN_MIN) ? 1 : 0, 1);
                if (n_srv < 4) srv[n_srv] = int'(grant_id);
                n_srv++;
                mg_run = 0;
            end
            if (state == 3'd3 || state == 3'd4) begin
                sel = req_pending >> grant_id;
                check("served_no_rerequest", int'(sel[0]), 0);
            end
            prev_state = state;
            @(negedge clk);
        end
        check("alt_services", (n_srv >= 4) ? 1 : 0, 1);
        check("alt_grant0", srv[0], 0);
        check("alt_grant1", srv[1], 1);
        check("alt_grant2", srv[2], 0);
        check("alt_grant3", srv[3], 1);

        // Randomized sensors, night requests and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            rnd = '0;
            for (int b = 0; b < N_SIDE; b++)
                rnd = (rnd << 1) | N_SIDE'($urandom_range(0, 15) == 0);
            side_sensor = rnd;
            if ($urandom_range(0, 199) == 0) night = ~night;
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlc_multi_fsm.md
TLC_MULTI_FSM -- requirements
Module: tlc_multi_fsm

Interface
REQ-001 SHALL have parameter N_SIDE, default 2: number of side-road approaches, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 6: phase counter width; elaboration SHALL fail if any T_* value exceeds 2**CNT_W.
REQ-003 SHALL have parameters T_MAIN_MIN=20, T_SIDE=10, T_YELLOW=4, T_ALLRED=2, T_FLASH=2: phase durations in clk cycles, each >=1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 side_sensor  input  N_SIDE  per-side vehicle-present level, synchronous to clk.
REQ-007 night  input  1  night/flash mode request level.
REQ-008 main_s  output  2  main-road lamp.
REQ-009 side_s  output  2*N_SIDE  side lamps; side i occupies bits [2i+1:2i].
REQ-010 state  output  3  current FSM state code.
REQ-011 grant_id  output  max(1,$clog2(N_SIDE))  index of the side currently or last served.
REQ-012 req_pending  output  N_SIDE  latched, not-yet-served requests.

Function
REQ-013 Lamp codes SHALL be RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 SHALL never be driven.
REQ-014 States SHALL be MAIN_GREEN=0, MAIN_YELLOW=1, ALLRED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALLRED_B=5, FLASH=6.
REQ-015 Internal phase counter SHALL clear to 0 on every state change; otherwise it SHALL increment each cycle, saturating at 2**CNT_W-1.
REQ-016 A timed state with duration T SHALL last exactly T cycles; it exits on the edge where count==T-1.
REQ-017 req_pending[i] SHALL set on any cycle with side_sensor[i]=1, except while side i is in SIDE_GREEN or SIDE_YELLOW.
REQ-018 req_pending[i] SHALL clear on entry to SIDE_GREEN for side i; if set and clear coincide, clear SHALL win.
REQ-019 MAIN_GREEN: main GREEN, all sides RED; exit to MAIN_YELLOW when count>=T_MAIN_MIN-1 and (req_pending!=0 or night=1); otherwise hold indefinitely.
REQ-020 MAIN_YELLOW: main YELLOW; lasts T_YELLOW cycles, then ALLRED_A.
REQ-021 ALLRED_A: all RED for T_ALLRED cycles; then FLASH if night=1, else SIDE_GREEN if req_pending!=0, else MAIN_GREEN.
REQ-022 On ALLRED_A->SIDE_GREEN, grant_id SHALL load the round-robin winner: first set req_pending bit scanning upward from grant_id+1, wrapping modulo N_SIDE.
REQ-023 SIDE_GREEN: side grant_id GREEN, main and other sides RED; lasts T_SIDE cycles, then SIDE_YELLOW (T_YELLOW cycles), then ALLRED_B.
REQ-024 ALLRED_B: all RED for T_ALLRED cycles, then MAIN_GREEN (main green always intervenes between two side greens).
REQ-025 FLASH: sides RED; main toggles YELLOW/RED every T_FLASH cycles, starting YELLOW; on night=0, exit to MAIN_GREEN at the end of the current T_FLASH interval.
REQ-026 Requests SHALL keep latching during FLASH and SHALL be served normally after exit.
REQ-027 At most one approach SHALL show non-RED in any cycle; all outputs SHALL be registered.

Reset
REQ-028 While rst=0: state=MAIN_GREEN, count=0, main_s=GREEN, all side_s=RED, req_pending=0, grant_id=N_SIDE-1 (side 0 wins first), flash phase=YELLOW.
REQ-029 Reset assertion mid-phase SHALL take effect immediately and asynchronously; after release, operation restarts at MAIN_GREEN with a full T_MAIN_MIN.

Structure
REQ-030 Package tlc_pkg SHALL hold lamp codes, state enumeration, and default timing constants.
REQ-031 Round-robin arbiter SHALL be a sub-module tlc_rr_arb (inputs req, last grant; output winner index, any).
REQ-032 Phase counter SHALL be internal to tlc_multi_fsm; there SHALL be no external counter or counter reset port.

Verification (defaults, cycle 0 = first edge after rst release)
REQ-033 No sensors for 200 cycles -> MAIN_GREEN throughout, main_s=GREEN, side_s=0.
REQ-034 side_sensor[1] pulse at cycle 5 -> MAIN_YELLOW at 20, ALLRED_A at 24, SIDE_GREEN grant_id=1 at 26, SIDE_YELLOW at 36, ALLRED_B at 40, MAIN_GREEN at 42; req_pending[1] clear from 26.
REQ-035 Both sensors held high -> sides served alternately 0,1,0,1 with main green of >=20 cycles between each.
REQ-036 night=1 at cycle 30 with no requests -> ALLRED_A, then FLASH with main_s YELLOW/RED toggling every 2 cycles; night=0 -> MAIN_GREEN at the next interval boundary.
REQ-037 rst=0 asserted during SIDE_GREEN -> same-cycle main_s=GREEN, side_s=0, req_pending=0, state=0.
REQ-038 Sensor of side being served held high through its green -> no re-request latched; it is set again only from ALLRED_B.
